// File: rtl/pc_gen_if.sv
// Fetch-side handshake bundle for the program-counter generator.
// Master drives the address; slave (instruction fetch) returns ready.
interface pc_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  pc_valid;
    logic                  pc_ready;
    logic [DATA_WIDTH-1:0] pc_current;

    modport master (
        output pc_valid,
        output pc_current,
        input  pc_ready
    );

    modport slave (
        input  pc_valid,
        input  pc_current,
        output pc_ready
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: boot cycle, trap entry/return, redirect,
// debug halt/resume and sequential fetch over a valid/ready handshake.
module pc_gen #(
    parameter int                  DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_1000,
    parameter int                  INST_BYTES   = 4,
    parameter int                  ALIGN_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_gen_if.master              fetch,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    input  logic                  trap_valid,
    input  logic [DATA_WIDTH-1:0] trap_vector,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    input  logic                  mret_valid,
    input  logic                  halt_req,
    input  logic                  resume_req,
    output logic [DATA_WIDTH-1:0] epc,
    output logic                  halted,
    output logic                  redirect_misalign
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic                  valid_q, valid_d;
    logic                  halted_q, halted_d;
    logic                  mis_q, mis_d;
    logic                  aligned;

    assign aligned = (redirect_target[ALIGN_BITS-1:0] == '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN, HALT: begin
                if (trap_valid) begin
                    pc_d    = trap_vector;
                    epc_d   = trap_pc;
                    state_d = RUN;
                end else if (mret_valid) begin
                    pc_d = epc_q;
                end else if (redirect_valid) begin
                    // Misaligned targets leave the PC alone; the pipeline traps.
                    if (aligned) pc_d = redirect_target;
                    else         mis_d = 1'b1;
                end else if (state_q == RUN) begin
                    if (halt_req)
                        state_d = HALT;
                    else if (valid_q && fetch.pc_ready)
                        pc_d = pc_q + DATA_WIDTH'(INST_BYTES);
                end else if (resume_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        valid_d  = (state_d == RUN);
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VECTOR;
            epc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
        end
    end

    assign fetch.pc_valid   = valid_q;
    assign fetch.pc_current = pc_q;
    assign epc               = epc_q;
    assign halted            = halted_q;
    assign redirect_misalign = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected outputs are queued with each
// stimulus step and popped for checking one clock later.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic [31:0] trap_pc;
    logic        mret_valid;
    logic        halt_req;
    logic        resume_req;
    logic [31:0] epc;
    logic        halted;
    logic        redirect_misalign;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        v;
        logic [31:0] epc;
        logic        h;
        logic        m;
    } exp_t;

    exp_t sb[$];

    pc_gen_if #(.DATA_WIDTH(32)) fif ();

    pc_gen dut (
        .clk               (clk),
        .rst               (rst),
        .fetch             (fif),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .trap_valid        (trap_valid),
        .trap_vector       (trap_vector),
        .trap_pc           (trap_pc),
        .mret_valid        (mret_valid),
        .halt_req          (halt_req),
        .resume_req        (resume_req),
        .epc               (epc),
        .halted            (halted),
        .redirect_misalign (redirect_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expectation, clock once, then pop and compare.
    task automatic step(input string tag, input logic [31:0] pc,
                        input logic v, input logic [31:0] e,
                        input logic h, input logic m);
        exp_t x;
        sb.push_back('{pc: pc, v: v, epc: e, h: h, m: m});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            x = sb.pop_front();
            chk({tag, ".pc"},     fif.pc_current,           x.pc);
            chk({tag, ".valid"},  {31'd0, fif.pc_valid},    {31'd0, x.v});
            chk({tag, ".epc"},    epc,                      x.epc);
            chk({tag, ".halted"}, {31'd0, halted},          {31'd0, x.h});
            chk({tag, ".mis"},    {31'd0, redirect_misalign}, {31'd0, x.m});
        end
    endtask

    task automatic idle();
        redirect_valid  = 1'b0;
        trap_valid      = 1'b0;
        mret_valid      = 1'b0;
        halt_req        = 1'b0;
        resume_req      = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        fif.pc_ready    = 1'b1;
        redirect_target = '0;
        trap_vector     = '0;
        trap_pc         = '0;
        idle();

        // reset, boot, run
        step("rst0",  32'h1000, 0, 0, 0, 0);
        step("boot",  32'h1000, 0, 0, 0, 0);
        rst = 1'b0;
        step("run0",  32'h1000, 1, 0, 0, 0);
        step("run1",  32'h1004, 1, 0, 0, 0);
        step("run2",  32'h1008, 1, 0, 0, 0);

        // backpressure
        fif.pc_ready = 1'b0;
        step("stall0", 32'h1008, 1, 0, 0, 0);
        step("stall1", 32'h1008, 1, 0, 0, 0);
        step("stall2", 32'h1008, 1, 0, 0, 0);
        fif.pc_ready = 1'b1;
        step("unstall", 32'h100C, 1, 0, 0, 0);

        // redirects while stalled
        fif.pc_ready    = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h2000;
        step("redir", 32'h2000, 1, 0, 0, 0);
        redirect_target = 32'h2002;
        step("misal", 32'h2000, 1, 0, 0, 1);
        redirect_valid = 1'b0;
        step("misal_end", 32'h2000, 1, 0, 0, 0);

        // trap beats a simultaneous redirect, then mret
        fif.pc_ready    = 1'b1;
        trap_valid      = 1'b1;
        trap_vector     = 32'h8000;
        trap_pc         = 32'h1010;
        redirect_valid  = 1'b1;
        redirect_target = 32'h4000;
        step("trap", 32'h8000, 1, 32'h1010, 0, 0);
        idle();
        step("handler", 32'h8004, 1, 32'h1010, 0, 0);
        mret_valid = 1'b1;
        step("mret", 32'h1010, 1, 32'h1010, 0, 0);
        idle();

        // halt, redirect in halt, resume
        halt_req = 1'b1;
        step("halt", 32'h1010, 0, 32'h1010, 1, 0);
        idle();
        step("halt_hold", 32'h1010, 0, 32'h1010, 1, 0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h3000;
        step("halt_redir", 32'h3000, 0, 32'h1010, 1, 0);
        idle();
        halt_req   = 1'b1;
        resume_req = 1'b1;
        step("resume", 32'h3000, 1, 32'h1010, 0, 0);
        idle();
        step("resume_adv", 32'h3004, 1, 32'h1010, 0, 0);
        halt_req   = 1'b1;
        resume_req = 1'b1;
        step("halt_wins", 32'h3004, 0, 32'h1010, 1, 0);
        idle();
        trap_valid  = 1'b1;
        trap_vector = 32'h8000;
        trap_pc     = 32'h3004;
        step("trap_halt", 32'h8000, 1, 32'h3004, 0, 0);
        idle();

        // wrap-around and mid-halt reset
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step("wrap_pre", 32'hFFFF_FFFC, 1, 32'h3004, 0, 0);
        idle();
        step("wrap", 32'h0000_0000, 1, 32'h3004, 0, 0);
        halt_req = 1'b1;
        step("halt2", 32'h0000_0000, 0, 32'h3004, 1, 0);
        idle();
        rst = 1'b1;
        step("rst_mid", 32'h1000, 0, 0, 0, 0);
        rst = 1'b0;
        step("reboot", 32'h1000, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
